// File: rtl/pe.sv
// pe: FP32 multiply-accumulate processing element for the systolic array.
// Each cycle the PE adds PE_a*PE_b into its accumulator, and PE_r shows the accumulator.
module pe (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PE_a,
  input  logic [31:0] PE_b,
  output logic [31:0] PE_r
);
  localparam logic [31:0] QNAN = 32'h7FC00000;
  logic [31:0] acc_q, acc_d, prod;
  function automatic logic [31:0] pack(input logic s, input logic signed [9:0] e, input logic [23:0] m,
                                       input logic g, input logic r, input logic st);
    logic [24:0] rm;
    logic signed [9:0] re;
    rm = {1'b0, m} + {24'd0, g & (r | st | m[0])};
    re = rm[24] ? e + 10'sd1 : e;
    return re <= 10'sd0 ? {s, 31'd0} : re >= 10'sd255 ? {s, 8'hFF, 23'd0} :
           {s, re[7:0], rm[24] ? rm[23:1] : rm[22:0]};
  endfunction
  function automatic logic [4:0] lzc(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 27; i++) n = v[i] ? 5'(26 - i) : n;
    return n;
  endfunction
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic s, za, zb, ia, ib;
    logic [47:0] p;
    logic signed [9:0] e;
    s = a[31] ^ b[31];
    za = a[30:23] == 8'd0;
    zb = b[30:23] == 8'd0;
    ia = a[30:23] == 8'hFF;
    ib = b[30:23] == 8'hFF;
    if ((ia && |a[22:0]) || (ib && |b[22:0]) || (ia && zb) || (ib && za)) return QNAN;
    if (ia || ib) return {s, 8'hFF, 23'd0};
    if (za || zb) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    return p[47] ? pack(s, e + 10'sd1, p[47:24], p[23], p[22], |p[21:0])
                 : pack(s, e, p[46:23], p[22], p[21], |p[20:0]);
  endfunction
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic zx, zy, ix, iy, sub;
    logic [31:0] bg, sm;
    logic [7:0] d;
    logic [53:0] sh;
    logic [26:0] al, nv;
    logic [27:0] sum;
    logic [4:0] lz;
    logic signed [9:0] e;
    zx = x[30:23] == 8'd0;
    zy = y[30:23] == 8'd0;
    ix = x[30:23] == 8'hFF;
    iy = y[30:23] == 8'hFF;
    if ((ix && |x[22:0]) || (iy && |y[22:0]) || (ix && iy && x[31] != y[31])) return QNAN;
    if (ix) return x;
    if (iy) return y;
    if (zx && zy) return {x[31] & y[31], 31'd0};
    if (zy) return x;
    if (zx) return y;
    bg = y[30:0] > x[30:0] ? y : x;
    sm = y[30:0] > x[30:0] ? x : y;
    sub = bg[31] ^ sm[31];
    d = bg[30:23] - sm[30:23];
    // bits shifted out of the 27-bit window fold into the sticky position
    sh = {1'b1, sm[22:0], 3'b000, 27'd0} >> d;
    al = d >= 8'd26 ? 27'd1 : {sh[53:28], |sh[27:0]};
    sum = sub ? {2'b01, bg[22:0], 3'b000} - {1'b0, al} : {2'b01, bg[22:0], 3'b000} + {1'b0, al};
    if (sum == 28'd0) return 32'd0;
    lz = lzc(sum[26:0]);
    nv = sum[27] ? {sum[27:2], sum[1] | sum[0]} : sum[26:0] << lz;
    e = $signed({2'b00, bg[30:23]}) + (sum[27] ? 10'sd1 : -$signed({5'd0, lz}));
    return pack(bg[31], e, nv[26:3], nv[2], nv[1], nv[0]);
  endfunction
  always_comb begin
    prod = fp_mul(PE_a, PE_b);
    acc_d = fp_add(acc_q, prod);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= 32'd0;
    else acc_q <= acc_d;
  end
  assign PE_r = acc_q;
endmodule

// File: tb/tb_pe.sv
// tb_pe: checks pe against an exact-arithmetic FP32 model (exact result, rounded once to nearest-even).
module tb_pe;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] ONE = 32'h3F800000;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] a = 32'h40000000, b = 32'h41000000, r;
  int n_pass = 0, n_tot = 0;
  logic [31:0] model;
  typedef struct { logic [31:0] a, b, r; } vec_t;
  vec_t tbl[25];

  pe dut (.clk(clk), .rst(rst), .PE_a(a), .PE_b(b), .PE_r(r));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic step(input logic [31:0] xa, input logic [31:0] xb);
    a = xa;
    b = xb;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("async_clear", r, 32'd0);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd(input logic s, input logic [127:0] m, input int e);
    int p, sh, be;
    logic [127:0] q, rem, half;
    if (m == 0) return {s, 31'd0};
    p = 127;
    while (!m[p]) p--;
    sh = p - 23;
    if (sh > 0) begin
      q = m >> sh;
      rem = m - (q << sh);
      half = 128'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q[24]) begin
        q = q >> 1;
        sh++;
      end
    end else q = m << (-sh);
    be = e + sh + 150;
    if (be <= 0) return {s, 31'd0};
    if (be >= 255) return {s, 8'hFF, 23'd0};
    return {s, be[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] x, input logic [31:0] y);
    logic s;
    bit xi, yi, xz, yz;
    s = x[31] ^ y[31];
    xi = x[30:23] == 8'hFF;
    yi = y[30:23] == 8'hFF;
    xz = x[30:23] == 0;
    yz = y[30:23] == 0;
    if ((xi && x[22:0] != 0) || (yi && y[22:0] != 0) || (xi && yz) || (yi && xz)) return QNAN;
    if (xi || yi) return {s, 8'hFF, 23'd0};
    if (xz || yz) return {s, 31'd0};
    return rnd(s, 128'({1'b1, x[22:0]}) * 128'({1'b1, y[22:0]}), int'(x[30:23]) + int'(y[30:23]) - 300);
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] y);
    bit xi, yi, xz, yz;
    int ex, ey, e;
    logic [127:0] mx, my;
    xi = x[30:23] == 8'hFF;
    yi = y[30:23] == 8'hFF;
    xz = x[30:23] == 0;
    yz = y[30:23] == 0;
    if ((xi && x[22:0] != 0) || (yi && y[22:0] != 0) || (xi && yi && x[31] != y[31])) return QNAN;
    if (xi) return x;
    if (yi) return y;
    if (xz && yz) return {x[31] & y[31], 31'd0};
    if (yz) return x;
    if (xz) return y;
    ex = int'(x[30:23]) - 150;
    ey = int'(y[30:23]) - 150;
    if (ex - ey > 60) return x;
    if (ey - ex > 60) return y;
    mx = 128'({1'b1, x[22:0]});
    my = 128'({1'b1, y[22:0]});
    if (ex >= ey) begin
      mx = mx << (ex - ey);
      e = ey;
    end else begin
      my = my << (ey - ex);
      e = ex;
    end
    if (x[31] == y[31]) return rnd(x[31], mx + my, e);
    if (mx == my) return 32'd0;
    return mx > my ? rnd(x[31], mx - my, e) : rnd(y[31], my - mx, e);
  endfunction

  function automatic logic [31:0] rfp(input int lo, input int hi, input bit sp);
    int k;
    logic [7:0] ex;
    logic [22:0] fr;
    logic sg;
    k = $urandom_range(0, 19);
    sg = 1'($urandom_range(0, 1));
    ex = 8'($urandom_range(lo, hi));
    fr = 23'($urandom);
    if (k == 0) return {sg, 31'd0};
    if (sp && k == 1) return {sg, 8'hFF, 23'd0};
    if (sp && k == 2) return {sg, 8'hFF, fr | 23'd1};
    if (sp && k == 3) return {sg, 8'h00, fr | 23'd1};
    return {sg, ex, fr};
  endfunction

  initial begin
    #1;
    chk("reset_no_edge", r, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(32'h40000000, 32'h41000000);
      chk("reset_hold", r, 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tbl[i] = '{32'd0, 32'd0, 32'd0};
    tbl[5]  = '{32'h40000000, 32'h41000000, 32'h41800000};
    tbl[6]  = '{32'h40000000, 32'h41000000, 32'h42000000};
    tbl[7]  = '{32'h40000000, 32'h41000000, 32'h42400000};
    tbl[8]  = '{32'h40000000, 32'h41000000, 32'h42800000};
    tbl[9]  = '{32'h40000000, 32'h41000000, 32'h42A00000};
    tbl[10] = '{32'h40800000, 32'h41000000, 32'h42E00000};
    tbl[11] = '{32'h40800000, 32'h41000000, 32'h43100000};
    tbl[12] = '{32'h40800000, 32'h41000000, 32'h43300000};
    tbl[13] = '{32'h40800000, 32'h41000000, 32'h43500000};
    tbl[14] = '{32'h40800000, 32'h41000000, 32'h43700000};
    tbl[15] = '{32'h41000000, 32'h41000000, 32'h43980000};
    tbl[16] = '{32'h41000000, 32'h41000000, 32'h43B80000};
    tbl[17] = '{32'h41000000, 32'h41000000, 32'h43D80000};
    tbl[18] = '{32'h41000000, 32'h41000000, 32'h43F80000};
    tbl[19] = '{32'h41000000, 32'h41000000, 32'h440C0000};
    tbl[20] = '{32'h41800000, 32'h41000000, 32'h442C0000};
    tbl[21] = '{32'h41800000, 32'h41000000, 32'h444C0000};
    tbl[22] = '{32'h41800000, 32'h41000000, 32'h446C0000};
    tbl[23] = '{32'h41800000, 32'h41000000, 32'h44860000};
    tbl[24] = '{32'h41800000, 32'h41000000, 32'h44960000};
    for (int i = 0; i < 25; i++) begin
      step(tbl[i].a, tbl[i].b);
      chk($sformatf("table[%0d]", i), r, tbl[i].r);
    end
    // inputs wiggling between edges must not matter
    a = 32'h7F800000;
    #2;
    step(32'h40000000, 32'h41000000);
    chk("between_edges", r, 32'h44980000);
    do_reset();
    step(32'h40000000, 32'h41000000);
    chk("restart_from_zero", r, 32'h41800000);
    do_reset();
    step(ONE, ONE);
    chk("acc_one", r, ONE);
    step(32'h33800000, ONE);
    chk("round_tie_even", r, ONE);
    step(32'h33C00000, ONE);
    chk("round_up", r, 32'h3F800001);
    step(32'h00000001, ONE);
    chk("subnormal_ignored", r, 32'h3F800001);
    do_reset();
    step(32'h41000000, ONE);
    chk("acc_eight", r, 32'h41000000);
    step(32'hC1000000, ONE);
    chk("cancel_pos_zero", r, 32'd0);
    step(32'h80000000, ONE);
    chk("neg_zero_add", r, 32'd0);
    do_reset();
    step(32'h7F000000, 32'h40000000);
    chk("overflow_inf", r, 32'h7F800000);
    step(ONE, 32'hBF800000);
    chk("inf_sticky", r, 32'h7F800000);
    step(32'hFF800000, ONE);
    chk("inf_minus_inf", r, QNAN);
    do_reset();
    step(32'h7F800000, 32'd0);
    chk("inf_times_zero", r, QNAN);
    step(ONE, ONE);
    chk("nan_sticky", r, QNAN);
    do_reset();
    model = 32'd0;
    for (int i = 0; i < 300; i++) begin
      a = rfp(118, 136, 1'b0);
      b = rfp(118, 136, 1'b0);
      model = m_add(model, m_mul(a, b));
      step(a, b);
      chk($sformatf("rand_mid[%0d]", i), r, model);
    end
    for (int i = 0; i < 300; i++) begin
      if (i % 16 == 0) begin
        do_reset();
        model = 32'd0;
      end
      a = rfp(1, 254, 1'b1);
      b = rfp(1, 254, 1'b1);
      model = m_add(model, m_mul(a, b));
      step(a, b);
      chk($sformatf("rand_wide[%0d]", i), r, model);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/pe.md
Name: pe

Overview:
- Single processing element (PE) for the systolic matrix-multiply accelerator.
- Each cycle it multiplies two IEEE-754 single-precision operands and adds the product into an internal FP32 accumulator.
- The accumulator is driven directly on PE_r as the partial dot product.
- Array-level dataflow is handled outside this block.

Parameters:
- None. Data width is fixed at 32 bits (IEEE-754 binary32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset; clears accumulator
- PE_a  input  32  FP32 operand A
- PE_b  input  32  FP32 operand B
- PE_r  output  32  FP32 accumulator value, registered

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: while rst=1, accumulator (and PE_r) = 32'h00000000 immediately, without waiting for a clock edge. It holds there until rst=0.
- Operation: on every rising clk edge with rst=0, acc <= fp_add(acc, fp_mul(PE_a, PE_b)). PE_r = acc.
- There is no enable and no handshake. The PE accumulates every cycle.
- Latency: 1 cycle. Inputs sampled at edge N are reflected on PE_r after edge N.
- Multiply and add are combinational between the input ports and the accumulator register.
- Multiplier:
  - Sign = sA xor sB.
  - Exponent = eA + eB - 127.
  - Mantissa: 24x24 unsigned product of the significands with hidden 1, then normalize by one position if bit 47 is set.
  - Rounding: round-to-nearest-even using guard/round/sticky bits; a rounding carry renormalizes.
- Adder:
  - Swap operands so the larger magnitude is first.
  - Align the smaller operand by the exponent difference, keeping guard/round/sticky bits. A shift of 26 or more collapses it to sticky only.
  - Add on equal signs, subtract on differing signs.
  - Normalize with a leading-zero count, then round-to-nearest-even.
- Special cases, both operators:
  - Subnormal inputs are treated as signed zero.
  - Results with biased exponent <= 0 flush to signed zero.
  - Biased exponent >= 255 gives signed infinity (exp=8'hFF, mantissa=0).
  - Any NaN input, inf*0, or (+inf)+(-inf) gives canonical quiet NaN 32'h7FC00000.
  - inf op finite gives the correctly signed infinity.
  - Exact cancellation in the adder gives +0.
  - 0*x gives a signed zero; adding that to acc leaves acc unchanged (except -0 + +0 = +0).
- Saturated states: once acc is inf or NaN it stays there per the rules above until reset.
- Reset mid-accumulation: rst asserted asynchronously discards any in-flight sum. The first edge after deassertion accumulates from 0.
- PE_a/PE_b changing between edges has no effect until the next edge.

Test Plan:
- rst=1 with PE_a=2.0, PE_b=8.0 toggling clk -> PE_r stays 32'h00000000. Asserting rst between edges clears PE_r immediately.
- After reset, PE_a=PE_b=0 for 5 cycles -> PE_r = 32'h00000000 throughout.
- PE_a=32'h40000000 (2.0), PE_b=32'h41000000 (8.0) for 5 cycles from acc=0 -> PE_r sequence 0x41800000, 0x42000000, 0x42400000, 0x42800000, 0x42A00000 (16, 32, 48, 64, 80).
- Continue with PE_a=32'h40800000 (4.0), PE_b=8.0 for 5 cycles -> PE_r increments by 32 each cycle to 240.0 (0x43700000). Then PE_a=8.0 (0x41000000) for 5 cycles -> reaches 560.0 (0x440C0000). Then PE_a=16.0 (0x41800000) for 5 cycles -> reaches 1200.0 (0x44960000).
- Rounding: acc=1.0 (0x3F800000), product 2^-24 (PE_a=0x33800000, PE_b=0x3F800000) -> PE_r stays 0x3F800000 (tie rounds to even). Product 3*2^-25 -> PE_r = 0x3F800001.
- Specials:
  - PE_a=0x7F800000, PE_b=0 -> PE_r=0x7FC00000.
  - From reset, PE_a=0x7F000000, PE_b=0x40000000 -> PE_r=0x7F800000.
  - Subnormal PE_a=0x00000001, PE_b=1.0 -> acc unchanged.
  - acc=8.0 plus product -8.0 -> PE_r=0x00000000.
